// File: rtl/timer_pkg.sv
// Shared constants and state encoding for the keypad timer entry stage.
package timer_pkg;

  localparam logic [3:0] KEY_CLEAR    = 4'hA;
  localparam logic [3:0] KEY_START    = 4'hB;
  localparam logic [3:0] MAX_SEC_TENS = 4'd5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ENTRY = 2'd1,
    ST_LOAD  = 2'd2,
    ST_ARMED = 2'd3
  } state_t;

  function automatic logic is_digit(input logic [3:0] k);
    return k <= 4'd9;
  endfunction

endpackage

// File: rtl/timer_entry_bcd_shift_buffer.sv
// Four-digit BCD shift buffer with digit count; new digits enter at sec_units.
module bcd_shift_buffer #(
  parameter int MAX_DIGITS = 4
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       clr,
  input  logic       shift,
  input  logic [3:0] din,
  output logic [3:0] sec_units,
  output logic [3:0] sec_tens,
  output logic [3:0] min_units,
  output logic [3:0] min_tens,
  output logic [2:0] count
);

  // Shift in a digit while not full; clear or reset empties the buffer.
  always_ff @(posedge clk) begin
    if (!clrn || clr) begin
      sec_units <= '0;
      sec_tens  <= '0;
      min_units <= '0;
      min_tens  <= '0;
      count     <= '0;
    end else if (shift && (count < 3'(MAX_DIGITS))) begin
      min_tens  <= min_units;
      min_units <= sec_tens;
      sec_tens  <= sec_units;
      sec_units <= din;
      count     <= count + 3'd1;
    end
  end

endmodule

// File: rtl/timer_entry.sv
// Keypad entry stage: collects MM:SS digits, validates, and loads the countdown.
module timer_entry
  import timer_pkg::*;
#(
  parameter int KEY_W      = 4,
  parameter int MAX_DIGITS = 4
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             key_valid,
  input  logic [KEY_W-1:0] key_code,
  input  logic             running,
  output logic [3:0]       sec_units,
  output logic [3:0]       sec_tens,
  output logic [3:0]       min_units,
  output logic [3:0]       min_tens,
  output logic             loadn,
  output logic             start,
  output logic             abort,
  output logic             entry_error,
  output logic [2:0]       digit_count
);

  state_t state, state_nxt;
  logic   loadn_nxt, start_nxt, abort_nxt, err_nxt;
  logic   run_prev, run_prev_nxt;
  logic   buf_clr, buf_shift;
  logic   key_digit, key_clr, key_start, run_fall, time_bad;

  assign key_digit = key_valid && is_digit(key_code[3:0]);
  assign key_clr   = key_valid && (key_code == KEY_W'(KEY_CLEAR));
  assign key_start = key_valid && (key_code == KEY_W'(KEY_START));
  assign time_bad  = (sec_tens > MAX_SEC_TENS) ||
                     ({min_tens, min_units, sec_tens, sec_units} == '0);

  // Completion is only watched after the start pulse, so the pre-start low
  // level of running is never mistaken for a falling edge.
  assign run_fall     = (state == ST_ARMED) && !start && run_prev && !running;
  assign run_prev_nxt = ((state == ST_ARMED) && !start) ? running : 1'b0;

  bcd_shift_buffer #(.MAX_DIGITS(MAX_DIGITS)) u_buf (
    .clk       (clk),
    .clrn      (clrn),
    .clr       (buf_clr),
    .shift     (buf_shift),
    .din       (key_code[3:0]),
    .sec_units (sec_units),
    .sec_tens  (sec_tens),
    .min_units (min_units),
    .min_tens  (min_tens),
    .count     (digit_count)
  );

  // State and registered strobe outputs.
  always_ff @(posedge clk) begin
    if (!clrn) begin
      state       <= ST_IDLE;
      loadn       <= 1'b1;
      start       <= 1'b0;
      abort       <= 1'b0;
      entry_error <= 1'b0;
      run_prev    <= 1'b0;
    end else begin
      state       <= state_nxt;
      loadn       <= loadn_nxt;
      start       <= start_nxt;
      abort       <= abort_nxt;
      entry_error <= err_nxt;
      run_prev    <= run_prev_nxt;
    end
  end

  // Next-state, next-strobe and buffer control decode.
  always_comb begin
    state_nxt = state;
    loadn_nxt = 1'b1;
    start_nxt = 1'b0;
    abort_nxt = 1'b0;
    err_nxt   = 1'b0;
    buf_clr   = 1'b0;
    buf_shift = 1'b0;
    unique case (state)
      ST_IDLE, ST_ENTRY: begin
        if (key_digit) begin
          if (digit_count < 3'(MAX_DIGITS)) begin
            buf_shift = 1'b1;
            state_nxt = ST_ENTRY;
          end
        end else if (key_clr) begin
          buf_clr   = 1'b1;
          state_nxt = ST_IDLE;
        end else if (key_start && (state == ST_ENTRY)) begin
          if (time_bad) begin
            err_nxt   = 1'b1;
            buf_clr   = 1'b1;
            state_nxt = ST_IDLE;
          end else begin
            loadn_nxt = 1'b0;
            state_nxt = ST_LOAD;
          end
        end
      end
      ST_LOAD: begin
        start_nxt = 1'b1;
        state_nxt = ST_ARMED;
      end
      ST_ARMED: begin
        if (key_clr) begin
          abort_nxt = 1'b1;
          buf_clr   = 1'b1;
          state_nxt = ST_IDLE;
        end else if (run_fall) begin
          buf_clr   = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_timer_entry.sv
// Self-checking bench for timer_entry: directed vector table plus random run
// against a queue-based model of the keypad entry rules.
module tb_timer_entry;

  logic       clk = 1'b0;
  logic       clrn, key_valid, running;
  logic [3:0] key_code;
  logic [3:0] sec_units, sec_tens, min_units, min_tens;
  logic       loadn, start, abort, entry_error;
  logic [2:0] digit_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  timer_entry #(.KEY_W(4), .MAX_DIGITS(4)) dut (
    .clk         (clk),
    .clrn        (clrn),
    .key_valid   (key_valid),
    .key_code    (key_code),
    .running     (running),
    .sec_units   (sec_units),
    .sec_tens    (sec_tens),
    .min_units   (min_units),
    .min_tens    (min_tens),
    .loadn       (loadn),
    .start       (start),
    .abort       (abort),
    .entry_error (entry_error),
    .digit_count (digit_count)
  );

  // {mt,mu,st,su} digits, {loadn,start,abort,entry_error} flags, count
  typedef struct {
    logic        c;
    logic        kv;
    logic [3:0]  kc;
    logic        r;
    logic [15:0] digs;
    logic [3:0]  flags;
    logic [2:0]  cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(input logic c, input logic kv, input logic [3:0] kc,
                             input logic r, input logic [15:0] digs,
                             input logic [3:0] flags, input logic [2:0] cnt);
    vec_t x;
    x.c = c; x.kv = kv; x.kc = kc; x.r = r;
    x.digs = digs; x.flags = flags; x.cnt = cnt;
    return x;
  endfunction

  function automatic logic [22:0] dut_vec();
    return {min_tens, min_units, sec_tens, sec_units,
            loadn, start, abort, entry_error, digit_count};
  endfunction

  task automatic check(input string name, input logic [22:0] act, input logic [22:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got digits=%h flags(ld,st,ab,er)=%b cnt=%0d, want digits=%h flags=%b cnt=%0d",
               name, act[22:7], act[6:3], act[2:0], exp[22:7], exp[6:3], exp[2:0]);
    end
  endtask

  // Reference model: entered digits kept as a queue, newest at the back.
  int q[$];
  int ph;          // 0 idle/entry, 1 load, 2 armed
  bit m_first;     // armed cycle carrying the start pulse
  bit m_rp;        // previous running, valid after the start cycle
  bit e_ln, e_st, e_ab, e_er;

  task automatic mstep(input bit c, input bit kv, input int kc, input bit r);
    bit was_first;
    bit fell;
    int st;
    int sum;
    was_first = m_first;
    e_ln = 1; e_st = 0; e_ab = 0; e_er = 0; m_first = 0;
    if (!c) begin
      q.delete(); ph = 0; m_rp = 0;
      return;
    end
    case (ph)
      0: if (kv) begin
        if (kc <= 9) begin
          if (q.size() < 4) q.push_back(kc);
        end else if (kc == 10) begin
          q.delete();
        end else if (kc == 11 && q.size() > 0) begin
          st  = (q.size() >= 2) ? q[q.size()-2] : 0;
          sum = 0;
          foreach (q[i]) sum += q[i];
          if (st > 5 || sum == 0) begin
            e_er = 1; q.delete();
          end else begin
            ph = 1; e_ln = 0;
          end
        end
      end
      1: begin
        ph = 2; e_st = 1; m_first = 1; m_rp = 0;
      end
      default: begin
        fell = !was_first && m_rp && !r;
        m_rp = was_first ? 1'b0 : r;
        if (kv && kc == 10) begin
          e_ab = 1; q.delete(); ph = 0;
        end else if (fell) begin
          q.delete(); ph = 0;
        end
      end
    endcase
  endtask

  function automatic logic [3:0] mdig(input int k);
    return (q.size() > k) ? 4'(q[q.size()-1-k]) : 4'd0;
  endfunction

  function automatic logic [22:0] mexp();
    return {mdig(3), mdig(2), mdig(1), mdig(0), e_ln, e_st, e_ab, e_er, 3'(q.size())};
  endfunction

  initial begin
    clrn = 1'b0; key_valid = 1'b0; key_code = '0; running = 1'b0;

    // reset
    tbl.push_back(v(0,0,4'h0,0,16'h0000,4'b1000,0));
    // 1,3,0 START -> 1:30, load then start
    tbl.push_back(v(1,1,4'h1,0,16'h0001,4'b1000,1));
    tbl.push_back(v(1,1,4'h3,0,16'h0013,4'b1000,2));
    tbl.push_back(v(1,1,4'h0,0,16'h0130,4'b1000,3));
    tbl.push_back(v(1,1,4'hB,0,16'h0130,4'b0000,3));
    tbl.push_back(v(1,0,4'h0,0,16'h0130,4'b1100,3));
    tbl.push_back(v(1,0,4'h0,1,16'h0130,4'b1000,3));
    tbl.push_back(v(1,1,4'h5,1,16'h0130,4'b1000,3));
    tbl.push_back(v(1,1,4'hB,1,16'h0130,4'b1000,3));
    tbl.push_back(v(1,0,4'h0,0,16'h0000,4'b1000,0));
    // START in IDLE ignored
    tbl.push_back(v(1,1,4'hB,0,16'h0000,4'b1000,0));
    tbl.push_back(v(1,0,4'h0,0,16'h0000,4'b1000,0));
    // five digits, fifth ignored; illegal code; CLEAR
    tbl.push_back(v(1,1,4'h1,0,16'h0001,4'b1000,1));
    tbl.push_back(v(1,1,4'h2,0,16'h0012,4'b1000,2));
    tbl.push_back(v(1,1,4'h3,0,16'h0123,4'b1000,3));
    tbl.push_back(v(1,1,4'h4,0,16'h1234,4'b1000,4));
    tbl.push_back(v(1,1,4'h5,0,16'h1234,4'b1000,4));
    tbl.push_back(v(1,1,4'hC,0,16'h1234,4'b1000,4));
    tbl.push_back(v(1,1,4'hA,0,16'h0000,4'b1000,0));
    // 7,5 START -> rejected
    tbl.push_back(v(1,1,4'h7,0,16'h0007,4'b1000,1));
    tbl.push_back(v(1,1,4'h5,0,16'h0075,4'b1000,2));
    tbl.push_back(v(1,1,4'hB,0,16'h0000,4'b1001,0));
    tbl.push_back(v(1,0,4'h0,0,16'h0000,4'b1000,0));
    // 0:45 armed, key during LOAD dropped, low running pre-run ignored, CLEAR aborts
    tbl.push_back(v(1,1,4'h4,0,16'h0004,4'b1000,1));
    tbl.push_back(v(1,1,4'h5,0,16'h0045,4'b1000,2));
    tbl.push_back(v(1,1,4'hB,0,16'h0045,4'b0000,2));
    tbl.push_back(v(1,1,4'h7,0,16'h0045,4'b1100,2));
    tbl.push_back(v(1,0,4'h0,0,16'h0045,4'b1000,2));
    tbl.push_back(v(1,0,4'h0,1,16'h0045,4'b1000,2));
    tbl.push_back(v(1,1,4'hA,1,16'h0000,4'b1010,0));
    tbl.push_back(v(1,0,4'h0,1,16'h0000,4'b1000,0));
    tbl.push_back(v(1,0,4'h0,0,16'h0000,4'b1000,0));
    // reset during LOAD, key 9 under reset not captured
    tbl.push_back(v(1,1,4'h2,0,16'h0002,4'b1000,1));
    tbl.push_back(v(1,1,4'h0,0,16'h0020,4'b1000,2));
    tbl.push_back(v(1,1,4'hB,0,16'h0020,4'b0000,2));
    tbl.push_back(v(0,0,4'h0,0,16'h0000,4'b1000,0));
    tbl.push_back(v(0,1,4'h9,0,16'h0000,4'b1000,0));
    tbl.push_back(v(1,0,4'h0,0,16'h0000,4'b1000,0));
    tbl.push_back(v(1,1,4'h1,0,16'h0001,4'b1000,1));

    foreach (tbl[i]) begin
      clrn = tbl[i].c; key_valid = tbl[i].kv; key_code = tbl[i].kc; running = tbl[i].r;
      @(posedge clk); #1;
      check($sformatf("vec%0d", i), dut_vec(),
            {tbl[i].digs, tbl[i].flags, tbl[i].cnt});
    end

    // randomized run against the model
    q.delete(); ph = 0; m_first = 0; m_rp = 0;
    clrn = 1'b0; key_valid = 1'b0; key_code = '0; running = 1'b0;
    @(posedge clk); #1;
    mstep(0, 0, 0, 0);
    check("rand_reset", dut_vec(), mexp());
    for (int n = 0; n < 4000; n++) begin
      int x;
      clrn      = ($urandom_range(0, 59) != 0);
      key_valid = ($urandom_range(0, 2) == 0);
      x = $urandom_range(0, 19);
      if (x <= 9)       key_code = 4'(x);
      else if (x <= 11) key_code = 4'($urandom_range(0, 5));
      else if (x <= 13) key_code = 4'hA;
      else if (x <= 17) key_code = 4'hB;
      else              key_code = 4'(x - 6);
      if ($urandom_range(0, 7) == 0) running = ~running;
      @(posedge clk); #1;
      mstep(clrn, key_valid, int'(key_code), running);
      check($sformatf("rand%0d", n), dut_vec(), mexp());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
